// File: rtl/writeback_buffer_if.sv
// writeback_buffer_if: lane inputs, register file write ports, forwarding lookup and occupancy
interface writeback_buffer_if #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
);
    logic                     in0Valid;
    logic                     in0Ready;
    logic [AW-1:0]            in0Reg;
    logic [DW-1:0]            in0Data;
    logic                     in1Valid;
    logic                     in1Ready;
    logic [AW-1:0]            in1Reg;
    logic [DW-1:0]            in1Data;
    logic                     we;
    logic [AW-1:0]            writeRegister;
    logic [DW-1:0]            writeData;
    logic                     we2;
    logic [AW-1:0]            writeRegister2;
    logic [DW-1:0]            writeData2;
    logic [AW-1:0]            lookupReg;
    logic                     lookupHit;
    logic [DW-1:0]            lookupData;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output in0Valid, in0Reg, in0Data, in1Valid, in1Reg, in1Data, lookupReg,
        input  in0Ready, in1Ready, we, writeRegister, writeData, we2, writeRegister2, writeData2,
               lookupHit, lookupData, count
    );

    modport slave (
        input  in0Valid, in0Reg, in0Data, in1Valid, in1Reg, in1Data, lookupReg,
        output in0Ready, in1Ready, we, writeRegister, writeData, we2, writeRegister2, writeData2,
               lookupHit, lookupData, count
    );
endinterface

// File: rtl/writeback_buffer.sv
// writeback_buffer: in-order two-lane result queue draining two register file writes per cycle, with forwarding
module writeback_buffer #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  logic              clk,
    input  logic              rst,
    writeback_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] q_reg  [DEPTH];
    logic [DW-1:0] q_data [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr, wr1_ptr;
    logic          acc0, acc1, deq1, deq2;
    logic [CW-1:0] enq_n, deq_n;

    assign bus.in0Ready = bus.count <= CW'(DEPTH - 1);
    assign bus.in1Ready = bus.count <= CW'(DEPTH - 2);
    assign acc0    = bus.in0Valid && bus.in0Ready && bus.in0Reg != '0;
    assign acc1    = bus.in1Valid && bus.in1Ready && bus.in1Reg != '0;
    assign wr1_ptr = wr_ptr + PW'(acc0);
    assign enq_n   = CW'(acc0) + CW'(acc1);
    assign deq1    = bus.count != '0;
    assign deq2    = bus.count >= CW'(2);
    assign deq_n   = CW'(deq1) + CW'(deq2);

    // queue storage: lane 0 lands before lane 1 so program order is kept
    always_ff @(posedge clk) begin
        if (acc0) begin
            q_reg[wr_ptr]  <= bus.in0Reg;
            q_data[wr_ptr] <= bus.in0Data;
        end
        if (acc1) begin
            q_reg[wr1_ptr]  <= bus.in1Reg;
            q_data[wr1_ptr] <= bus.in1Data;
        end
    end

    // pointers, occupancy and the one-cycle output stage; dequeue only sees entries present before this edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr             <= '0;
            wr_ptr             <= '0;
            bus.count          <= '0;
            bus.we             <= 1'b0;
            bus.writeRegister  <= '0;
            bus.writeData      <= '0;
            bus.we2            <= 1'b0;
            bus.writeRegister2 <= '0;
            bus.writeData2     <= '0;
        end else begin
            rd_ptr             <= rd_ptr + PW'(deq_n);
            wr_ptr             <= wr_ptr + PW'(enq_n);
            bus.count          <= bus.count + enq_n - deq_n;
            bus.we             <= deq1;
            bus.writeRegister  <= deq1 ? q_reg[rd_ptr] : '0;
            bus.writeData      <= deq1 ? q_data[rd_ptr] : '0;
            bus.we2            <= deq2;
            bus.writeRegister2 <= deq2 ? q_reg[rd_ptr + PW'(1)] : '0;
            bus.writeData2     <= deq2 ? q_data[rd_ptr + PW'(1)] : '0;
        end
    end

    // forwarding: later matches override earlier ones, so youngest pending value wins
    always_comb begin
        bus.lookupHit  = 1'b0;
        bus.lookupData = '0;
        if (bus.we && bus.writeRegister == bus.lookupReg) begin
            bus.lookupHit  = 1'b1;
            bus.lookupData = bus.writeData;
        end
        if (bus.we2 && bus.writeRegister2 == bus.lookupReg) begin
            bus.lookupHit  = 1'b1;
            bus.lookupData = bus.writeData2;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < bus.count && q_reg[rd_ptr + PW'(i)] == bus.lookupReg) begin
                bus.lookupHit  = 1'b1;
                bus.lookupData = q_data[rd_ptr + PW'(i)];
            end
        end
        if (bus.lookupReg == '0) begin
            bus.lookupHit  = 1'b0;
            bus.lookupData = '0;
        end
    end
endmodule
